branch_resolve_ctrl: RTL and testbench

- EX-stage controller that sequences the branch comparator.
- Accepts one conditional branch at a time, waits for forwarded operands, and resolves taken/not-taken through an internal comparator sub-module.
- Compares the outcome with the front-end prediction and issues redirect/flush on a mispredict.
- Owns a direct-mapped 2-bit saturating branch history table (BHT) that the IF stage reads for predictions.

---
 rtl/branch_pkg.sv | 35 +++
 rtl/branch_cond_eval.sv | 38 +++
 rtl/branch_resolve_ctrl.sv | 154 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the EX-stage branch resolution slice:
//   - funct3 branch condition codes (BR_EQ .. BR_GEU)
//   - controller state enum (IDLE / WAIT / RESOLVE)
//   - BHT 2-bit saturating counter type, its reset value and update function
// -----------------------------------------------------------------------------
package branch_pkg;

   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESOLVE = 2'd2
   } state_t;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t WEAK_NT = 2'b01;

   // Saturating step: taken counts up to 2'b11, not-taken down to 2'b00.
   function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
      bht_ctr_t r;
      if (taken) r = (ctr == 2'b11) ? ctr : bht_ctr_t'(ctr + 2'd1);
      else       r = (ctr == 2'b00) ? ctr : bht_ctr_t'(ctr - 2'd1);
      return r;
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
// Combinational branch comparator.
//   i_a, i_b    : operands (rs1, rs2)
//   i_branch    : instruction is a conditional branch
//   i_funct3    : condition code (see branch_pkg)
//   o_taken     : condition holds; always 0 for non-branches and 010/011
// -----------------------------------------------------------------------------
module branch_cond_eval
   import branch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  logic            i_branch,
   input  logic [2:0]      i_funct3,
   output logic            o_taken
);

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // o_taken unassigned (which would infer a latch).
      o_taken = 1'b0;
      if (i_branch) begin
         case (i_funct3)
            BR_EQ:   o_taken = (i_a == i_b);
            BR_NE:   o_taken = (i_a != i_b);
            BR_LT:   o_taken = ($signed(i_a) <  $signed(i_b));
            BR_GE:   o_taken = ($signed(i_a) >= $signed(i_b));
            BR_LTU:  o_taken = (i_a <  i_b);
            BR_GEU:  o_taken = (i_a >= i_b);
            default: o_taken = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
// EX-stage branch controller: accepts one branch, waits for forwarded
// operands, resolves it through branch_cond_eval, flags mispredicts and trains
// a direct-mapped 2-bit BHT that the IF stage reads.
//   clk, rst                      : clock, synchronous active-high reset
//   br_valid/br_ready             : branch handshake into EX
//   br_pc/br_imm/br_funct3        : branch PC, B-type offset, condition
//   br_pred_taken                 : prediction the front end followed
//   rs1_val/rs2_val/ops_ready     : forwarded operands and their valid
//   ex_kill                       : higher-priority squash of a waiting branch
//   if_pc/pred_taken              : IF lookup, combinational counter MSB
//   stall                         : hold front end while waiting for operands
//   resolved_valid/resolved_taken : one-cycle resolution pulse and outcome
//   redirect_valid/redirect_pc    : mispredict pulse and correct next PC
//   flush                         : kill younger IF/ID with the redirect
// -----------------------------------------------------------------------------
module branch_resolve_ctrl
   import branch_pkg::*;
#(
   parameter int BHT_IDX_W = 6,
   parameter int XLEN      = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_valid,
   output logic            br_ready,
   input  logic [XLEN-1:0] br_pc,
   input  logic [XLEN-1:0] br_imm,
   input  logic [2:0]      br_funct3,
   input  logic            br_pred_taken,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic            ops_ready,
   input  logic            ex_kill,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic            stall,
   output logic            resolved_valid,
   output logic            resolved_taken,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush
);

   localparam int BHT_ENTRIES = 2 ** BHT_IDX_W;

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_imm;
   logic [2:0]      r_funct3;
   logic            r_pred;
   logic            r_stall;
   logic            r_resolved_valid;
   logic            r_resolved_taken;
   logic            r_redirect_valid;
   logic            r_redirect_pc_vld_unused;
   logic [XLEN-1:0] r_redirect_pc;
   logic            r_flush;
   bht_ctr_t        r_bht [BHT_ENTRIES];

   logic                 w_taken;
   logic                 w_capture;
   logic [BHT_IDX_W-1:0] w_upd_idx;
   logic [BHT_IDX_W-1:0] w_lookup_idx;
   logic                 w_unused_if_pc;

   branch_cond_eval #(.XLEN(XLEN)) u_cond (
      .i_a      (rs1_val),
      .i_b      (rs2_val),
      .i_branch (1'b1),
      .i_funct3 (r_funct3),
      .o_taken  (w_taken)
   );

   // A new branch can be taken in IDLE and in RESOLVE (back-to-back).
   assign br_ready  = (r_state != WAIT);
   assign w_capture = br_valid && br_ready;

   assign w_upd_idx    = r_pc[BHT_IDX_W+1:2];
   assign w_lookup_idx = if_pc[BHT_IDX_W+1:2];
   // Plain array read: an update on the same edge is seen only afterwards.
   assign pred_taken   = r_bht[w_lookup_idx][1];

   assign w_unused_if_pc = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= IDLE;
         r_pc             <= '0;
         r_imm            <= '0;
         r_funct3         <= '0;
         r_pred           <= 1'b0;
         r_stall          <= 1'b0;
         r_resolved_valid <= 1'b0;
         r_resolved_taken <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_flush          <= 1'b0;
         r_redirect_pc_vld_unused <= 1'b0;
         // NOTE: the BHT is a small flop array that must start weakly
         // not-taken, so it is reset explicitly rather than left to RAM init.
         for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= WEAK_NT;
      end else begin
         // Pulses default low; only the WAIT->RESOLVE edge raises them.
         r_resolved_valid <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_flush          <= 1'b0;
         r_redirect_pc_vld_unused <= 1'b0;

         if (w_capture) begin
            r_pc     <= br_pc;
            r_imm    <= br_imm;
            r_funct3 <= br_funct3;
            r_pred   <= br_pred_taken;
         end

         case (r_state)
            IDLE, RESOLVE: begin
               r_stall <= w_capture;
               r_state <= w_capture ? WAIT : IDLE;
            end
            WAIT: begin
               // Squash wins over operand arrival: nothing is reported.
               if (ex_kill) begin
                  r_stall <= 1'b0;
                  r_state <= IDLE;
               end else if (ops_ready) begin
                  r_stall          <= 1'b0;
                  r_resolved_valid <= 1'b1;
                  r_resolved_taken <= w_taken;
                  r_redirect_valid <= (w_taken != r_pred);
                  r_flush          <= (w_taken != r_pred);
                  r_redirect_pc    <= w_taken ? (r_pc + r_imm) : (r_pc + XLEN'(4));
                  r_bht[w_upd_idx] <= bht_next(r_bht[w_upd_idx], w_taken);
                  r_state          <= RESOLVE;
               end
            end
            default: begin
               r_stall <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign stall          = r_stall;
   assign resolved_valid = r_resolved_valid;
   assign resolved_taken = r_resolved_taken;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign flush          = r_flush;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
// Directed self-checking bench for branch_resolve_ctrl. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;
   import branch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        br_valid;
   logic        br_ready;
   logic [31:0] br_pc;
   logic [31:0] br_imm;
   logic [2:0]  br_funct3;
   logic        br_pred_taken;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        ops_ready;
   logic        ex_kill;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic        stall;
   logic        resolved_valid;
   logic        resolved_taken;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.BHT_IDX_W(6), .XLEN(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .br_valid       (br_valid),
      .br_ready       (br_ready),
      .br_pc          (br_pc),
      .br_imm         (br_imm),
      .br_funct3      (br_funct3),
      .br_pred_taken  (br_pred_taken),
      .rs1_val        (rs1_val),
      .rs2_val        (rs2_val),
      .ops_ready      (ops_ready),
      .ex_kill        (ex_kill),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .stall          (stall),
      .resolved_valid (resolved_valid),
      .resolved_taken (resolved_taken),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      br_valid  = 1'b0;
      ops_ready = 1'b0;
      ex_kill   = 1'b0;
   endtask

   task automatic offer(input logic [31:0] pc, input logic [31:0] imm,
                        input logic [2:0] f3, input logic pred);
      br_valid      = 1'b1;
      br_pc         = pc;
      br_imm        = imm;
      br_funct3     = f3;
      br_pred_taken = pred;
   endtask

   task automatic give_ops(input logic [31:0] a, input logic [31:0] b);
      ops_ready = 1'b1;
      rs1_val   = a;
      rs2_val   = b;
   endtask

   // Offer from IDLE, land in WAIT and confirm the waiting outputs.
   task automatic accept(input string tag, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [2:0] f3, input logic pred);
      offer(pc, imm, f3, pred);
      tick();
      idle_inputs();
      check({tag, "_wait_stall"}, {31'd0, stall}, 32'd1);
      check({tag, "_wait_ready"}, {31'd0, br_ready}, 32'd0);
   endtask

   task automatic check_resolve(input string tag, input logic taken,
                                input logic redir, input logic [31:0] rpc);
      check({tag, "_rvalid"}, {31'd0, resolved_valid}, 32'd1);
      check({tag, "_rtaken"}, {31'd0, resolved_taken}, {31'd0, taken});
      check({tag, "_redir"},  {31'd0, redirect_valid}, {31'd0, redir});
      check({tag, "_flush"},  {31'd0, flush},          {31'd0, redir});
      check({tag, "_rpc"},    redirect_pc,             rpc);
      check({tag, "_stall"},  {31'd0, stall},          32'd0);
      check({tag, "_ready"},  {31'd0, br_ready},       32'd1);
   endtask

   initial begin
      logic [1:0] exp_up [4];
      logic [1:0] exp_dn [4];
      logic [1:0] prev;

      exp_up = '{2'b10, 2'b11, 2'b11, 2'b11};
      exp_dn = '{2'b10, 2'b01, 2'b00, 2'b00};

      rst = 1'b1;
      idle_inputs();
      offer(32'd0, 32'd0, BR_EQ, 1'b0);
      br_valid = 1'b0;
      rs1_val  = '0;
      rs2_val  = '0;
      if_pc    = 32'h100;
      tick();
      tick();

      // Reset state.
      check("rst_stall",  {31'd0, stall},          32'd0);
      check("rst_rvalid", {31'd0, resolved_valid}, 32'd0);
      check("rst_redir",  {31'd0, redirect_valid}, 32'd0);
      check("rst_flush",  {31'd0, flush},          32'd0);
      check("rst_rpc",    redirect_pc,             32'd0);
      check("rst_ready",  {31'd0, br_ready},       32'd1);
      check("rst_pred",   {31'd0, pred_taken},     32'd0);
      check("rst_bht0",   {30'd0, dut.r_bht[0]},   32'd1);
      rst = 1'b0;
      tick();

      // beq taken against a not-taken prediction: redirect to pc+imm.
      accept("beq", 32'h100, 32'h20, BR_EQ, 1'b0);
      check("beq_wait_rvalid", {31'd0, resolved_valid}, 32'd0);
      give_ops(32'h5, 32'h5);
      tick();
      idle_inputs();
      check_resolve("beq", 1'b1, 1'b1, 32'h120);
      check("beq_bht0", {30'd0, dut.r_bht[0]}, 32'd2);
      check("beq_pred", {31'd0, pred_taken},   32'd1);
      tick();
      check("beq_idle_rvalid", {31'd0, resolved_valid}, 32'd0);
      check("beq_idle_redir",  {31'd0, redirect_valid}, 32'd0);

      // blt signed -1 < 1 taken, correctly predicted.
      accept("blt", 32'h204, 32'h10, BR_LT, 1'b1);
      give_ops(32'hFFFF_FFFF, 32'h1);
      tick();
      idle_inputs();
      check_resolve("blt", 1'b1, 1'b0, 32'h214);

      // bltu offered back-to-back during RESOLVE: 0xFFFFFFFF <u 1 is false.
      offer(32'h208, 32'h10, BR_LTU, 1'b1);
      tick();
      idle_inputs();
      check("b2b_wait_stall",  {31'd0, stall},          32'd1);
      check("b2b_wait_rvalid", {31'd0, resolved_valid}, 32'd0);
      give_ops(32'hFFFF_FFFF, 32'h1);
      tick();
      idle_inputs();
      check_resolve("bltu", 1'b0, 1'b1, 32'h20C);
      check("bltu_bht2", {30'd0, dut.r_bht[2]}, 32'd0);
      tick();

      // Operands late for 5 cycles; funct3 010 resolves not-taken.
      accept("hold", 32'h30C, 32'h8, 3'b010, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("hold_stall",  {31'd0, stall},          32'd1);
         check("hold_ready",  {31'd0, br_ready},       32'd0);
         check("hold_rvalid", {31'd0, resolved_valid}, 32'd0);
         tick();
      end
      give_ops(32'h5, 32'h5);
      tick();
      idle_inputs();
      check_resolve("f3_010", 1'b0, 1'b0, 32'h310);
      check("f3_010_bht3", {30'd0, dut.r_bht[3]}, 32'd0);
      tick();

      // ex_kill beats ops_ready in WAIT: no report, BHT[1] stays 2'b10.
      accept("kill", 32'h204, 32'h10, BR_EQ, 1'b0);
      give_ops(32'h5, 32'h5);
      ex_kill = 1'b1;
      tick();
      idle_inputs();
      check("kill_rvalid", {31'd0, resolved_valid}, 32'd0);
      check("kill_redir",  {31'd0, redirect_valid}, 32'd0);
      check("kill_stall",  {31'd0, stall},          32'd0);
      check("kill_ready",  {31'd0, br_ready},       32'd1);
      check("kill_bht1",   {30'd0, dut.r_bht[1]},   32'd2);
      tick();
      check("kill_late_rvalid", {31'd0, resolved_valid}, 32'd0);

      // Saturation at pc=0x40 (index 16), with same-edge lookup.
      if_pc = 32'h40;
      prev  = 2'b01;
      for (int i = 0; i < 8; i++) begin
         logic [1:0] want;
         want = (i < 4) ? exp_up[i] : exp_dn[i-4];
         accept("sat", 32'h40, 32'h4, (i < 4) ? BR_EQ : BR_NE, 1'b1);
         give_ops(32'h1, 32'h1);
         check("sat_lookup_old", {31'd0, pred_taken}, {31'd0, prev[1]});
         tick();
         idle_inputs();
         check("sat_rtaken", {31'd0, resolved_taken}, (i < 4) ? 32'd1 : 32'd0);
         check("sat_ctr",    {30'd0, dut.r_bht[16]},  {30'd0, want});
         check("sat_pred",   {31'd0, pred_taken},     {31'd0, want[1]});
         prev = want;
         tick();
      end

      // PC wrap: 0xFFFFFFFC + 8 = 0x4.
      accept("wrap", 32'hFFFF_FFFC, 32'h8, BR_EQ, 1'b0);
      give_ops(32'h0, 32'h0);
      tick();
      idle_inputs();
      check_resolve("wrap", 1'b1, 1'b1, 32'h4);
      check("wrap_bht63", {30'd0, dut.r_bht[63]}, 32'd2);
      tick();

      // Reset while waiting: branch abandoned, outputs and BHT cleared.
      accept("rstw", 32'hFFFF_FFFC, 32'h8, BR_EQ, 1'b1);
      give_ops(32'h0, 32'h0);
      rst = 1'b1;
      tick();
      idle_inputs();
      rst = 1'b0;
      check("rstw_stall",  {31'd0, stall},          32'd0);
      check("rstw_rvalid", {31'd0, resolved_valid}, 32'd0);
      check("rstw_rtaken", {31'd0, resolved_taken}, 32'd0);
      check("rstw_redir",  {31'd0, redirect_valid}, 32'd0);
      check("rstw_flush",  {31'd0, flush},          32'd0);
      check("rstw_rpc",    redirect_pc,             32'd0);
      check("rstw_ready",  {31'd0, br_ready},       32'd1);
      check("rstw_bht63",  {30'd0, dut.r_bht[63]},  32'd1);
      check("rstw_bht0",   {30'd0, dut.r_bht[0]},   32'd1);
      check("rstw_bht16",  {30'd0, dut.r_bht[16]},  32'd1);
      check("rstw_pred",   {31'd0, pred_taken},     32'd0);
      tick();
      check("rstw_post_rvalid", {31'd0, resolved_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
